// File: rtl/fft_feeder_pkg.sv
// ---------------------------------------------------------------------------
// fft_feeder_pkg : shared types and helpers for the FFT frame feeder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fft_feeder_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_DATA = 2'd1,
    R_PAD  = 2'd2
  } rd_state_t;

  localparam int SAT_CNT_W = 16;

  typedef logic [SAT_CNT_W-1:0] sat_cnt_t;
  typedef logic [1:0]           sat_inc_t;

  // Clamp a sign-extended sample into the signed range of out_w bits.
  function automatic logic signed [31:0] sat_to_out(input logic signed [31:0] x,
                                                     input int               out_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (x > hi)
      sat_to_out = hi;
    else if (x < lo)
      sat_to_out = lo;
    else
      sat_to_out = x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_feeder_bank.sv
// ---------------------------------------------------------------------------
// fft_feeder_bank : ping-pong frame store, lane write port, registered row read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_feeder_bank #(
  parameter int ROWS  = 32,
  parameter int LANES = 16,
  parameter int OUT_W = 9,
  parameter int RW    = 5,
  parameter int LW    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_en,
  input  logic                    i_wr_bank,
  input  logic [RW-1:0]           i_wr_row,
  input  logic [LW-1:0]           i_wr_lane,
  input  logic signed [OUT_W-1:0] i_wr_re,
  input  logic signed [OUT_W-1:0] i_wr_im,
  input  logic                    i_rd_en,
  input  logic                    i_rd_zero,
  input  logic                    i_rd_bank,
  input  logic [RW-1:0]           i_rd_row,
  output logic signed [OUT_W-1:0] o_rd_re [0:LANES-1],
  output logic signed [OUT_W-1:0] o_rd_im [0:LANES-1]
);

  logic [2*OUT_W-1:0]      r_mem [0:2*ROWS-1][0:LANES-1];
  logic signed [OUT_W-1:0] r_re  [0:LANES-1];
  logic signed [OUT_W-1:0] r_im  [0:LANES-1];

  // Storage is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (i_wr_en)
      r_mem[{i_wr_bank, i_wr_row}][i_wr_lane] <= {i_wr_re, i_wr_im};
  end

  always_ff @(posedge clk) begin
    if (rst || i_rd_zero) begin
      for (int j = 0; j < LANES; j++) begin
        r_re[j] <= '0;
        r_im[j] <= '0;
      end
    end else if (i_rd_en) begin
      for (int j = 0; j < LANES; j++) begin
        r_re[j] <= r_mem[{i_rd_bank, i_rd_row}][j][2*OUT_W-1:OUT_W];
        r_im[j] <= r_mem[{i_rd_bank, i_rd_row}][j][OUT_W-1:0];
      end
    end
  end

  assign o_rd_re = r_re;
  assign o_rd_im = r_im;

endmodule

`default_nettype wire

// File: rtl/fft_frame_feeder.sv
// ---------------------------------------------------------------------------
// fft_frame_feeder : serial complex stream to padded LANES-wide FFT bursts
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_frame_feeder
  import fft_feeder_pkg::*;
#(
  parameter int N        = 512,
  parameter int LANES    = 16,
  parameter int IN_W     = 16,
  parameter int OUT_W    = 9,
  parameter int PAD_BLKS = 2,
  parameter int GAP_CYC  = 1,
  parameter int SAT_EN   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [IN_W-1:0]  s_real,
  input  logic signed [IN_W-1:0]  s_imag,
  input  logic                    s_last,
  output logic                    o_valid,
  output logic signed [OUT_W-1:0] dout_i [0:LANES-1],
  output logic signed [OUT_W-1:0] dout_q [0:LANES-1],
  output logic                    frame_done,
  output logic                    err_len,
  output logic [15:0]             sat_cnt
);

  localparam int ROWS    = N / LANES;
  localparam int IW      = $clog2(N);
  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int RW      = IW - LW;
  localparam int CNT_MAX = (ROWS > PAD_BLKS) ? ROWS : PAD_BLKS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int GW      = $clog2(GAP_CYC + 1);

  logic            r_post_rst;
  logic [1:0]      r_full;
  logic            r_wr_bank;
  logic            r_rd_bank;
  logic [IW-1:0]   r_wr_idx;
  rd_state_t       r_state;
  rd_state_t       w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [GW-1:0]   r_gap;
  logic            r_o_valid;
  logic            r_frame_done;
  logic            r_err_len;
  sat_cnt_t        r_sat_cnt;

  logic            w_acc;
  logic            w_idx_last;
  logic            w_fill;
  logic            w_drop;
  logic            w_row_last;
  logic            w_pad_last;
  logic            w_free;
  logic            w_start;
  logic            w_rd_en;
  logic            w_rd_zero;
  logic            w_valid_nxt;
  logic            w_done_nxt;

  logic signed [31:0]      w_re_ext;
  logic signed [31:0]      w_im_ext;
  logic signed [31:0]      w_re_sat;
  logic signed [31:0]      w_im_sat;
  logic signed [OUT_W-1:0] w_re_out;
  logic signed [OUT_W-1:0] w_im_out;
  sat_inc_t                w_inc;
  logic [16:0]             w_sat_sum;

  // ---------------- write side ----------------
  assign s_ready    = !r_post_rst && !(r_full[0] && r_full[1]);
  assign w_acc      = s_valid && s_ready;
  assign w_idx_last = (r_wr_idx == IW'(N - 1));
  assign w_fill     = w_acc && w_idx_last;
  assign w_drop     = w_acc && s_last && !w_idx_last;

  assign w_re_ext = 32'(s_real);
  assign w_im_ext = 32'(s_imag);
  assign w_re_sat = sat_to_out(w_re_ext, OUT_W);
  assign w_im_sat = sat_to_out(w_im_ext, OUT_W);
  assign w_re_out = (SAT_EN != 0) ? w_re_sat[OUT_W-1:0] : s_real[OUT_W-1:0];
  assign w_im_out = (SAT_EN != 0) ? w_im_sat[OUT_W-1:0] : s_imag[OUT_W-1:0];
  assign w_inc    = (SAT_EN != 0)
                  ? (sat_inc_t'(w_re_sat != w_re_ext) + sat_inc_t'(w_im_sat != w_im_ext))
                  : 2'd0;
  assign w_sat_sum = {1'b0, r_sat_cnt} + {15'd0, w_inc};

  always_ff @(posedge clk) begin
    r_post_rst <= rst;
    if (rst) begin
      r_wr_idx  <= '0;
      r_wr_bank <= 1'b0;
      r_err_len <= 1'b0;
      r_sat_cnt <= '0;
    end else begin
      r_err_len <= w_drop;
      if (w_fill || w_drop)
        r_wr_idx <= '0;
      else if (w_acc)
        r_wr_idx <= r_wr_idx + IW'(1);
      if (w_fill)
        r_wr_bank <= !r_wr_bank;
      if (w_acc)
        r_sat_cnt <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
    end
  end

  // Fill and free always target different banks, so per-bank priority is safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_fill && (r_wr_bank == 1'(b)))
          r_full[b] <= 1'b1;
        else if (w_free && (r_rd_bank == 1'(b)))
          r_full[b] <= 1'b0;
      end
    end
  end

  // ---------------- read FSM ----------------
  assign w_row_last = (r_cnt == CW'(ROWS - 1));
  assign w_pad_last = (r_cnt == CW'(PAD_BLKS - 1));
  assign w_free     = (r_state == R_DATA) && w_row_last;
  assign w_start    = r_full[r_rd_bank] && (r_gap >= GW'(GAP_CYC));

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= R_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (w_start) w_state_nxt = R_DATA;
      R_DATA:  if (w_row_last) w_state_nxt = (PAD_BLKS == 0) ? R_IDLE : R_PAD;
      R_PAD:   if (w_pad_last) w_state_nxt = R_IDLE;
      default: w_state_nxt = R_IDLE;
    endcase
  end

  // Outputs are registered one cycle behind the state that produces them.
  always_comb begin
    w_rd_en     = (r_state == R_DATA);
    w_rd_zero   = (r_state != R_DATA);
    w_valid_nxt = (r_state != R_IDLE);
    w_done_nxt  = (r_state == R_IDLE) && r_o_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_gap        <= GW'(GAP_CYC);
      r_rd_bank    <= 1'b0;
      r_o_valid    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_o_valid    <= w_valid_nxt;
      r_frame_done <= w_done_nxt;
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (r_state != R_IDLE)
        r_cnt <= r_cnt + CW'(1);
      if (r_state != R_IDLE)
        r_gap <= '0;
      else if (r_gap < GW'(GAP_CYC))
        r_gap <= r_gap + GW'(1);
      if (w_free)
        r_rd_bank <= !r_rd_bank;
    end
  end

  fft_feeder_bank #(
    .ROWS  (ROWS),
    .LANES (LANES),
    .OUT_W (OUT_W),
    .RW    (RW),
    .LW    (LW)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_acc),
    .i_wr_bank (r_wr_bank),
    .i_wr_row  (r_wr_idx[IW-1:LW]),
    .i_wr_lane (r_wr_idx[LW-1:0]),
    .i_wr_re   (w_re_out),
    .i_wr_im   (w_im_out),
    .i_rd_en   (w_rd_en),
    .i_rd_zero (w_rd_zero),
    .i_rd_bank (r_rd_bank),
    .i_rd_row  (r_cnt[RW-1:0]),
    .o_rd_re   (dout_i),
    .o_rd_im   (dout_q)
  );

  assign o_valid    = r_o_valid;
  assign frame_done = r_frame_done;
  assign err_len    = r_err_len;
  assign sat_cnt    = r_sat_cnt;

endmodule

`default_nettype wire
